ddr_rd_responder: RTL and testbench



---
 rtl/ddr_rsp_pkg.sv | 16 +
 rtl/ddr_line_ram.sv | 25 ++
 rtl/ddr_rd_responder.sv | 119 +++++++++++
 tb/tb_ddr_rd_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ddr_rsp_pkg.sv
// Shared constants, state encoding and LFSR step for the DDR line-read responder.
// DDR_RSP_JITTER_EN (in the top) enables the LFSR-driven latency jitter that uses these.
package ddr_rsp_pkg;
  localparam int LINE_BITS  = 512;
  localparam int LINE_SHIFT = 9;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} rsp_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/ddr_line_ram.sv
// Simple dual-port line store: one write port, one registered read port.
// A same-cycle write to the line being read returns the old contents.
module ddr_line_ram #(
  parameter int DEPTH = 1024,
  parameter int W     = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH)) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ddr_rd_responder.sv
// Responder end of the 512-bit DDR line-read interface, backed by an on-chip line array.
// Optional: define DDR_RSP_JITTER_EN to add 0..7 LFSR-chosen extra cycles of latency.
module ddr_rd_responder
  import ddr_rsp_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = LINE_BITS,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ddr_rd,
  input  logic [ADDR_W-1:0]              readAdd,
  output logic                           ddr_rd_valid,
  output logic                           ddr_rd_done,
  output logic [DATA_W-1:0]              ddr_rd_data,
  output logic                           rd_err,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_LINES)-1:0] wr_line,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           busy
);
  localparam int IDX_W = ADDR_W - LINE_SHIFT;
  localparam int AW    = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 8);

  rsp_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              oor_q, err_q, valid_q, rd_err_q, busy_q;
  logic [DATA_W-1:0] last_q;

  logic [IDX_W-1:0]  idx;
  logic              misal, oor, accept;
  logic [DATA_W-1:0] ram_q, rsp_data;
  logic [2:0]        extra;
  logic [CNT_W-1:0]  cnt_init;

  assign idx    = readAdd[ADDR_W-1:LINE_SHIFT];
  assign misal  = |readAdd[LINE_SHIFT-1:0];
  assign oor    = idx >= IDX_W'(DEPTH_LINES);
  assign accept = (state_q == IDLE) && ddr_rd && !rst;

  ddr_line_ram #(.DEPTH(DEPTH_LINES), .W(DATA_W)) u_ram (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wr_line),
    .wdata_i(wr_data),
    .re_i   (accept),
    .raddr_i(idx[AW-1:0]),
    .rdata_o(ram_q)
  );

`ifdef DDR_RSP_JITTER_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_next(lfsr_q);
  end
  assign extra = lfsr_q[2:0];
`else
  assign extra = 3'd0;
`endif

  assign cnt_init = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  // The RAM read register is the hold register; out-of-range lines read back as zero.
  assign rsp_data    = oor_q ? '0 : ram_q;
  assign ddr_rd_data = (state_q == RESP) ? rsp_data : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      oor_q    <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      rd_err_q <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (ddr_rd) begin
          oor_q <= oor;
          err_q <= oor | misal;
          if (cnt_init == '0) begin
            state_q  <= RESP;
            valid_q  <= 1'b1;
            rd_err_q <= oor | misal;
          end else begin
            state_q <= WAIT;
            cnt_q   <= cnt_init;
            busy_q  <= 1'b1;
          end
        end
        WAIT: if (cnt_q == CNT_W'(1)) begin
          state_q  <= RESP;
          busy_q   <= 1'b0;
          valid_q  <= 1'b1;
          rd_err_q <= err_q;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        RESP: begin
          state_q  <= IDLE;
          valid_q  <= 1'b0;
          rd_err_q <= 1'b0;
          last_q   <= rsp_data;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ddr_rd_valid = valid_q;
  assign ddr_rd_done  = valid_q;
  assign rd_err       = rd_err_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_ddr_rd_responder.sv
// Directed bench for ddr_rd_responder: aligned/error reads, held request, write hazard, reset abort, jitter.
module tb_ddr_rd_responder;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst, ddr_rd, wr_en;
  logic [31:0]  readAdd;
  logic [9:0]   wr_line;
  logic [511:0] wr_data, ddr_rd_data;
  logic         ddr_rd_valid, ddr_rd_done, rd_err, busy;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] seen = 8'h00;

  localparam logic [511:0] L3   = {64{8'hA5}};
  localparam logic [511:0] L5   = {16{32'h5555_0005}};
  localparam logic [511:0] NEW1 = {16{32'h1111_0005}};
  localparam logic [511:0] NEW2 = {16{32'h2222_0005}};
  localparam logic [511:0] L0   = {16{32'hDEAD_0000}};
  localparam logic [511:0] LTOP = {16{32'h0000_03FF}};
  localparam logic [511:0] L7   = {16{32'h7777_0007}};
  localparam logic [511:0] L8   = {16{32'h8888_0008}};

  ddr_rd_responder #(.ADDR_W(32), .DATA_W(512), .DEPTH_LINES(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .ddr_rd(ddr_rd), .readAdd(readAdd),
    .ddr_rd_valid(ddr_rd_valid), .ddr_rd_done(ddr_rd_done), .ddr_rd_data(ddr_rd_data),
    .rd_err(rd_err), .wr_en(wr_en), .wr_line(wr_line), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int i);
    return {16{32'hC0DE_0000 ^ 32'(i)}};
  endfunction

  task automatic load(input int line, input logic [511:0] d);
    wr_en = 1'b1; wr_line = 10'(line); wr_data = d;
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issues one pulse request from a negedge in IDLE and checks the single response.
  task automatic rd_txn(input logic [31:0] addr, input logic [511:0] exp_d, input logic exp_e,
                        input bit hz, input string tag);
    int lat, npulse;
    logic [511:0] got_d;
    logic got_e, got_done, got_busy;
    lat = 0; npulse = 0; got_d = '0; got_e = 1'b0; got_done = 1'b0; got_busy = 1'b1;
    readAdd = addr; ddr_rd = 1'b1;
    if (hz) begin wr_en = 1'b1; wr_line = 10'd5; wr_data = NEW1; end
    @(posedge clk); @(negedge clk);
    ddr_rd = 1'b0; wr_en = 1'b0;
    chk({tag, "_busy"}, {511'd0, busy}, 512'd1);
    for (int k = 1; k <= LAT + 10; k++) begin
      if (ddr_rd_valid) begin
        npulse++;
        if (lat == 0) begin
          lat = k; got_d = ddr_rd_data; got_e = rd_err; got_done = ddr_rd_done; got_busy = busy;
        end
      end
      if (hz && k == 2) begin wr_en = 1'b1; wr_line = 10'd5; wr_data = NEW2; end
      if (hz && k == 3) wr_en = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_npulse"}, 512'(npulse), 512'd1);
`ifdef DDR_RSP_JITTER_EN
    chk({tag, "_latrange"}, {511'd0, (lat >= LAT && lat <= LAT + 7)}, 512'd1);
    if (lat >= LAT && lat <= LAT + 7) seen[lat - LAT] = 1'b1;
`else
    chk({tag, "_lat"}, 512'(lat), 512'(LAT));
`endif
    chk({tag, "_data"}, got_d, exp_d);
    chk({tag, "_err"}, {511'd0, got_e}, {511'd0, exp_e});
    chk({tag, "_done"}, {511'd0, got_done}, 512'd1);
    chk({tag, "_busyrsp"}, {511'd0, got_busy}, 512'd0);
    chk({tag, "_hold"}, ddr_rd_data, exp_d);
    chk({tag, "_errlow"}, {511'd0, rd_err}, 512'd0);
  endtask

  initial begin
    int v1, v2, np, b5, b6, nv;
    logic [511:0] d1;
    rst = 1'b1; ddr_rd = 1'b0; wr_en = 1'b0; readAdd = '0; wr_line = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {511'd0, ddr_rd_valid}, 512'd0);
    chk("rst_done",  {511'd0, ddr_rd_done}, 512'd0);
    chk("rst_err",   {511'd0, rd_err}, 512'd0);
    chk("rst_busy",  {511'd0, busy}, 512'd0);
    chk("rst_data",  ddr_rd_data, 512'd0);
    rst = 1'b0;
    @(negedge clk);

    load(3, L3); load(5, L5); load(0, L0); load(1023, LTOP); load(7, L7);

    rd_txn(32'd1536, L3, 1'b0, 1'b0, "aligned");
    rd_txn(32'd1537, L3, 1'b1, 1'b0, "misal");
    rd_txn(32'd1024 * 512, 512'd0, 1'b1, 1'b0, "oor");
    rd_txn(32'd1024 * 512 + 7, 512'd0, 1'b1, 1'b0, "oor_misal");
    rd_txn(32'd1023 * 512, LTOP, 1'b0, 1'b0, "lastline");
    rd_txn(32'd5 * 512, L5, 1'b0, 1'b1, "hazard");
    rd_txn(32'd5 * 512, NEW2, 1'b0, 1'b0, "after_hz");

`ifndef DDR_RSP_JITTER_EN
    // Held level: one response, then re-accept five edges after the first accept.
    v1 = 0; v2 = 0; np = 0; b5 = -1; b6 = -1; d1 = '0;
    readAdd = 32'd0; ddr_rd = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      if (ddr_rd_valid) begin
        np++;
        if (v1 == 0) begin v1 = k; d1 = ddr_rd_data; end
        else if (v2 == 0) v2 = k;
      end
      if (k == 5) b5 = int'(busy);
      if (k == 6) begin b6 = int'(busy); ddr_rd = 1'b0; end
      @(negedge clk);
    end
    chk("held_v1", 512'(v1), 512'd4);
    chk("held_data", d1, L0);
    chk("held_busy5", 512'(b5), 512'd0);
    chk("held_busy6", 512'(b6), 512'd1);
    chk("held_v2", 512'(v2), 512'd9);
    chk("held_np", 512'(np), 512'd2);
`endif

    // Abort in WAIT; a load issued during reset must still land.
    readAdd = 32'd7 * 512; ddr_rd = 1'b1;
    @(posedge clk); @(negedge clk);
    ddr_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_line = 10'd8; wr_data = L8;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    chk("abort_busy",  {511'd0, busy}, 512'd0);
    chk("abort_valid", {511'd0, ddr_rd_valid}, 512'd0);
    chk("abort_err",   {511'd0, rd_err}, 512'd0);
    chk("abort_data",  ddr_rd_data, 512'd0);
    nv = 0;
    for (int k = 0; k < 14; k++) begin
      if (ddr_rd_valid) nv++;
      @(negedge clk);
    end
    chk("abort_nopulse", 512'(nv), 512'd0);
    rd_txn(32'd7 * 512, L7, 1'b0, 1'b0, "reread");
    rd_txn(32'd8 * 512, L8, 1'b0, 1'b0, "rstload");

`ifdef DDR_RSP_JITTER_EN
    for (int i = 0; i < 16; i++) load(100 + i, pat(100 + i));
    for (int n = 0; n < 1000; n++) begin
      int ln;
      ln = 100 + int'($urandom_range(0, 15));
      rd_txn(32'(ln) * 512, pat(ln), 1'b0, 1'b0, "jit");
    end
    chk("jit_seen", {504'd0, seen}, {504'd0, 8'hFF});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
